data_distributor: RTL and testbench
===================================

// Module: data_distributor
// PURPOSE
//  Clocked 1-to-N packet demultiplexer: the inverse of the 2:1 data selector.
//  Steers a valid/ready word stream from one source to one of N_OUT sink channels.
//  The route is chosen by SEL on the first beat of a packet and held until the
//  D_LAST beat. Each channel has a one-entry output register, so channels drain
//  independently. Sits between a single producer (UART RX, switch bank) and N consumers.
// PARAMETERS
//  WIDTH   8  data word width in bits
//  N_OUT   4  number of output channels, 2..16
//  SEL_W   2  SEL width; must satisfy 2**SEL_W >= N_OUT
// PORTS
//  CLK         in   1           single clock; all logic on rising edge
//  RST_N       in   1           reset, synchronous, active-low
//  D           in   WIDTH       input data word
//  D_VALID     in   1           input word present
//  D_LAST      in   1           final beat of the packet
//  D_READY     out  1           block accepts the word this cycle
//  SEL         in   SEL_W       target channel; sampled on the first beat only
//  Q           out  N_OUT*WIDTH channel i data on Q[i*WIDTH +: WIDTH]
//  Q_VALID     out  N_OUT       channel i holds a word
//  Q_LAST      out  N_OUT       channel i word is the last beat of its packet
//  Q_READY     in   N_OUT       sink i takes the word this cycle
//  ACTIVE_SEL  out  SEL_W       latched route of the current packet
//  BUSY        out  1           packet in progress (state != IDLE)
//  ERR         out  1           one-cycle pulse: packet started with SEL >= N_OUT
// BEHAVIOUR
//  - Reset (RST_N=0 at an edge): state=IDLE; Q, Q_VALID, Q_LAST, ACTIVE_SEL, ERR = 0.
//    Reset mid-packet discards buffered and in-flight words.
//  - Transfer: a beat is accepted when D_VALID & D_READY. tgt = SEL in IDLE, ACTIVE_SEL otherwise.
//  - D_READY (combinational) = DROP | ~Q_VALID[tgt] | Q_READY[tgt].
//    In IDLE with SEL >= N_OUT, D_READY = 1.
//  - FSM states: IDLE, ROUTE, DROP.
//    IDLE, accept, SEL < N_OUT: ACTIVE_SEL <= SEL; next state is ROUTE, or IDLE if D_LAST.
//    IDLE, accept, SEL >= N_OUT: ERR=1 for one cycle; beat discarded;
//      next state is DROP, or IDLE if D_LAST.
//    ROUTE: SEL ignored. Accepted beats go to ACTIVE_SEL. Accept with D_LAST -> IDLE.
//    DROP: every beat is accepted and discarded. Accept with D_LAST -> IDLE.
//  - Output slot i:
//    Load on an accepted beat with tgt==i (not DROP). Q/Q_LAST/Q_VALID update at the next edge.
//    Latency is 1 cycle from input accept to Q_VALID.
//    Clears on Q_READY[i] with no load.
//    Load and drain in the same cycle: new word is stored and Q_VALID stays 1.
//    Q and Q_LAST are stable while Q_VALID=1 and Q_READY=0.
//  - Stalled channels (Q_VALID=1, Q_READY=0) backpressure only packets routed to them.
//    Other channels keep draining.
//  - ACTIVE_SEL keeps its last value in IDLE. BUSY = (state != IDLE).
//  - No combinational path from D to Q; Q_READY -> D_READY is the only comb path.
// STRUCTURE
//  - Shared header data_dist_defs.vh holds:
//    state encodings ST_IDLE=2'd0, ST_ROUTE=2'd1, ST_DROP=2'd2, and a clog2 function.
//  - Sub-module out_slot (WIDTH): one-entry valid/ready register with load/drain.
//    Instantiated N_OUT times via generate.
//  - Top level holds the FSM, the target decode and the D_READY mux.
// TESTING
//  1 Reset: hold RST_N=0 for 2 cycles with D_VALID=1.
//    -> Q_VALID=0, D_READY=1, BUSY=0, ERR=0 throughout.
//  2 Single-beat packet: D=8'hA5, SEL=2, D_LAST=1.
//    -> next cycle Q_VALID=4'b0100, Q[23:16]=8'hA5, Q_LAST[2]=1, BUSY stays 0.
//  3 Three-beat packet, SEL=1 on beat 1 then SEL=3 on beats 2-3, Q_READY[1]=1.
//    -> all three words appear on channel 1 only; BUSY=1 until the D_LAST accept.
//  4 Backpressure: channel 0 full with Q_READY[0]=0 and a new packet to channel 0.
//    -> D_READY=0.
//    Raise Q_READY[0] -> same-cycle accept, Q_VALID[0] stays 1, Q[7:0]=new word.
//  5 Out-of-range route (N_OUT=3, SEL=3), 2-beat packet.
//    -> ERR pulses once, no Q_VALID change, D_READY=1, returns to IDLE after D_LAST.
//  6 Reset asserted mid-packet (state ROUTE).
//    -> next cycle BUSY=0 and Q_VALID=0; the next beat routes by fresh SEL.

Source files
------------

// File: rtl/data_distributor_pkg.sv
// Shared definitions for the data distributor: FSM state encodings and a
// ceiling-log2 helper for sizing select fields from a channel count.
package data_distributor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Smallest r such that 2**r >= value
  function automatic int dd_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_distributor_out_slot.sv
// One-entry valid/ready output register. A load always wins over a drain so a
// word can be replaced in the same cycle the sink takes the previous one.
module data_distributor_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             din_last,
  input  logic             drain,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_last
);

  logic [WIDTH-1:0] data_r;
  logic             last_r;
  logic             valid_r;

  // Hold the buffered word; data and last only change on a load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= {WIDTH{1'b0}};
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= din;
      last_r  <= din_last;
      valid_r <= 1'b1;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign q       = data_r;
  assign q_last  = last_r;
  assign q_valid = valid_r;

endmodule

// File: rtl/data_distributor.sv
// Clocked 1-to-N packet demultiplexer. The route is taken from sel on the
// first beat of a packet and held until the last beat; packets that start
// with an out-of-range sel are swallowed whole and flagged with err.
module data_distributor
  import data_distributor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       d,
  input  logic                   d_valid,
  input  logic                   d_last,
  output logic                   d_ready,
  input  logic [SEL_W-1:0]       sel,
  output logic [N_OUT*WIDTH-1:0] q,
  output logic [N_OUT-1:0]       q_valid,
  output logic [N_OUT-1:0]       q_last,
  input  logic [N_OUT-1:0]       q_ready,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   busy,
  output logic                   err
);

  // Channel count widened by one bit so sel can be range-checked without overflow
  localparam logic [SEL_W:0] N_OUT_C = (SEL_W+1)'(N_OUT);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [SEL_W-1:0] active_sel_r;
  logic             err_r;

  logic [SEL_W-1:0] tgt_s;
  logic             sel_ok_s;
  logic             drop_s;
  logic             tgt_qv_s;
  logic             tgt_qr_s;
  logic             d_ready_s;
  logic             accept_s;
  logic [N_OUT-1:0] load_s;

  // Pick the target channel and decide whether the current beat is discarded
  always_comb begin
    tgt_s    = active_sel_r;
    drop_s   = 1'b0;
    sel_ok_s = ({1'b0, sel} < N_OUT_C);
    if (state_r == ST_IDLE) begin
      tgt_s  = sel;
      drop_s = ~sel_ok_s;
    end else if (state_r == ST_DROP) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Ready mux over the target slot and per-slot load strobes
  always_comb begin
    tgt_qv_s = 1'b0;
    tgt_qr_s = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      tgt_qv_s = tgt_qv_s | (q_valid[i] & (tgt_s == SEL_W'(i)));
      tgt_qr_s = tgt_qr_s | (q_ready[i] & (tgt_s == SEL_W'(i)));
    end
    d_ready_s = drop_s | ~tgt_qv_s | tgt_qr_s;
    accept_s  = d_valid & d_ready_s;
    for (int i = 0; i < N_OUT; i++) begin
      load_s[i] = accept_s & ~drop_s & (tgt_s == SEL_W'(i));
    end
  end

  // Packet framing FSM: IDLE opens a packet, ROUTE/DROP run until the last beat
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (d_last) begin
            state_nxt_s = ST_IDLE;
          end else if (sel_ok_s) begin
            state_nxt_s = ST_ROUTE;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ROUTE, ST_DROP: begin
        if (accept_s && d_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched route and error pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      active_sel_r <= {SEL_W{1'b0}};
      err_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      err_r   <= accept_s & (state_r == ST_IDLE) & ~sel_ok_s;
      if (accept_s && (state_r == ST_IDLE) && sel_ok_s) begin
        active_sel_r <= sel;
      end else begin
        active_sel_r <= active_sel_r;
      end
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
    data_distributor_out_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s[gi]),
      .din      (d),
      .din_last (d_last),
      .drain    (q_ready[gi]),
      .q        (q[gi*WIDTH +: WIDTH]),
      .q_valid  (q_valid[gi]),
      .q_last   (q_last[gi])
    );
  end

  assign d_ready    = d_ready_s;
  assign active_sel = active_sel_r;
  assign busy       = (state_r != ST_IDLE);
  assign err        = err_r;

endmodule

// File: tb/tb_data_distributor.sv
// Scoreboard bench for data_distributor: accepted beats push the expected
// word onto a per-channel queue, a negedge monitor pops and compares on
// every output handshake. A second instance with three channels exercises
// the out-of-range route.
module tb_data_distributor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d;
  logic        d_valid;
  logic        d_last;
  logic [1:0]  sel;
  logic [3:0]  q_ready;
  logic        d_ready;
  logic [31:0] q;
  logic [3:0]  q_valid;
  logic [3:0]  q_last;
  logic [1:0]  active_sel;
  logic        busy;
  logic        err;

  logic [7:0]  d3;
  logic        d3_valid;
  logic        d3_last;
  logic [1:0]  sel3;
  logic [2:0]  q_ready3;
  logic        d3_ready;
  logic [23:0] q3;
  logic [2:0]  q_valid3;
  logic [2:0]  q_last3;
  logic [1:0]  active_sel3;
  logic        busy3;
  logic        err3;

  int checks = 0;
  int errors = 0;
  int err3_cnt = 0;

  logic [8:0] sb [4][$];
  logic       model_busy = 1'b0;
  logic [1:0] model_route = 2'd0;

  always #5 clk = ~clk;

  data_distributor #(.WIDTH(8), .N_OUT(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_last(d_last),
    .d_ready(d_ready), .sel(sel), .q(q), .q_valid(q_valid), .q_last(q_last),
    .q_ready(q_ready), .active_sel(active_sel), .busy(busy), .err(err)
  );

  data_distributor #(.WIDTH(8), .N_OUT(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .d_valid(d3_valid), .d_last(d3_last),
    .d_ready(d3_ready), .sel(sel3), .q(q3), .q_valid(q_valid3), .q_last(q_last3),
    .q_ready(q_ready3), .active_sel(active_sel3), .busy(busy3), .err(err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on a channel must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (q_valid[i] && q_ready[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ch%0d_unexpected: got %0h expected no word", i, q[i*8 +: 8]);
          end else begin
            logic [8:0] e;
            e = sb[i].pop_front();
            check($sformatf("ch%0d_data", i), 32'(q[i*8 +: 8]), 32'(e[7:0]));
            check($sformatf("ch%0d_last", i), 32'(q_last[i]), 32'(e[8]));
          end
        end
      end
    end
  end

  // Count error pulses of the three-channel instance
  always @(negedge clk) begin
    if (err3 === 1'b1) err3_cnt++;
  end

  // Drive one beat, wait for acceptance, record the expected word
  task automatic send(input logic [7:0] data, input logic [1:0] s, input logic last);
    int n;
    logic [1:0] tgt;
    n = 0;
    d = data; sel = s; d_last = last; d_valid = 1'b1;
    @(negedge clk);
    while (!d_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!d_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got d_ready=0 expected 1 within 50 cycles");
    end else begin
      tgt = model_busy ? model_route : s;
      sb[tgt].push_back({last, data});
      model_busy  = ~last;
      model_route = tgt;
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    d = 8'hFF; sel = 2'd1; d_last = 1'b0; d_valid = 1'b1; q_ready = 4'h0;
    d3 = 8'h00; sel3 = 2'd0; d3_last = 1'b0; d3_valid = 1'b0; q_ready3 = 3'b000;

    // 1: reset held two cycles with d_valid high
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_q_valid", 32'(q_valid), 32'h0);
      check("rst_d_ready", 32'(d_ready), 32'h1);
      check("rst_busy",    32'(busy),    32'h0);
      check("rst_err",     32'(err),     32'h0);
    end
    check("rst_q",          q,                32'h0);
    check("rst_active_sel", 32'(active_sel), 32'h0);
    d_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: single-beat packet to channel 2
    send(8'hA5, 2'd2, 1'b1);
    check("t2_q_valid", 32'(q_valid),  32'h4);
    check("t2_q2",      32'(q[23:16]), 32'hA5);
    check("t2_q_last2", 32'(q_last[2]), 32'h1);
    check("t2_busy",    32'(busy),     32'h0);
    q_ready = 4'b0100;
    @(posedge clk); #1;
    check("t2_drained", 32'(q_valid), 32'h0);

    // 3: three-beat packet, sel changes after the first beat
    q_ready = 4'b1111;
    send(8'h31, 2'd1, 1'b0);
    check("t3_busy_b1",   32'(busy),          32'h1);
    check("t3_asel",      32'(active_sel),    32'h1);
    check("t3_only_ch1a", 32'(q_valid & 4'b1101), 32'h0);
    send(8'h32, 2'd3, 1'b0);
    check("t3_busy_b2",   32'(busy),          32'h1);
    check("t3_only_ch1b", 32'(q_valid & 4'b1101), 32'h0);
    send(8'h33, 2'd3, 1'b1);
    check("t3_busy_b3",   32'(busy),          32'h0);
    check("t3_only_ch1c", 32'(q_valid & 4'b1101), 32'h0);
    @(posedge clk); #1;

    // 4: backpressure on channel 0, then same-cycle drain and load
    q_ready = 4'b0000;
    send(8'h11, 2'd0, 1'b1);
    check("t4_full", 32'(q_valid[0]), 32'h1);
    d = 8'h22; sel = 2'd0; d_last = 1'b1; d_valid = 1'b1;
    @(negedge clk);
    check("t4_ready_low", 32'(d_ready), 32'h0);
    check("t4_q0_held",   32'(q[7:0]),  32'h11);
    @(posedge clk); #1;
    q_ready = 4'b0001;
    @(negedge clk);
    check("t4_ready_high", 32'(d_ready), 32'h1);
    sb[0].push_back({1'b1, 8'h22});
    @(posedge clk); #1;
    d_valid = 1'b0;
    check("t4_valid_kept", 32'(q_valid[0]), 32'h1);
    check("t4_q0_new",     32'(q[7:0]),     32'h22);
    @(posedge clk); #1;

    // 5: three-channel instance, in-range boundary then out-of-range packet
    d3 = 8'h5A; sel3 = 2'd2; d3_last = 1'b1; d3_valid = 1'b1;
    @(negedge clk);
    check("t5_ready_sel2", 32'(d3_ready), 32'h1);
    @(posedge clk); #1;
    d3_valid = 1'b0;
    check("t5_sel2_valid", 32'(q_valid3),   32'h4);
    check("t5_sel2_data",  32'(q3[23:16]), 32'h5A);
    check("t5_sel2_err",   32'(err3),      32'h0);
    q_ready3 = 3'b111;
    @(posedge clk); #1;
    q_ready3 = 3'b000;
    d3 = 8'hE1; sel3 = 2'd3; d3_last = 1'b0; d3_valid = 1'b1;
    @(negedge clk);
    check("t5_ready_b1", 32'(d3_ready), 32'h1);
    @(posedge clk); #1;
    check("t5_err_pulse", 32'(err3),  32'h1);
    check("t5_busy_drop", 32'(busy3), 32'h1);
    d3 = 8'hE2; sel3 = 2'd0; d3_last = 1'b1;
    @(negedge clk);
    check("t5_ready_b2", 32'(d3_ready), 32'h1);
    @(posedge clk); #1;
    d3_valid = 1'b0;
    check("t5_err_low",   32'(err3),     32'h0);
    check("t5_idle",      32'(busy3),    32'h0);
    check("t5_no_output", 32'(q_valid3), 32'h0);
    @(posedge clk); #1;
    check("t5_err_count", 32'(err3_cnt), 32'h1);

    // 6: reset in the middle of a routed packet
    q_ready = 4'b0000;
    send(8'h41, 2'd1, 1'b0);
    check("t6_busy_before", 32'(busy),    32'h1);
    check("t6_q1_loaded",   32'(q_valid), 32'h2);
    rst_n = 1'b0;
    d = 8'h42; sel = 2'd1; d_last = 1'b0; d_valid = 1'b1;
    for (int i = 0; i < 4; i++) sb[i].delete();
    model_busy = 1'b0;
    @(posedge clk); #1;
    d_valid = 1'b0;
    check("t6_busy_after", 32'(busy),    32'h0);
    check("t6_q_cleared",  32'(q_valid), 32'h0);
    rst_n = 1'b1;
    send(8'h55, 2'd2, 1'b1);
    check("t6_fresh_route", 32'(q_valid),  32'h4);
    check("t6_fresh_data",  32'(q[23:16]), 32'h55);

    // Drain everything and confirm every expected word was seen
    q_ready = 4'b1111;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sb%0d_empty", i), 32'(sb[i].size()), 32'h0);
    end
    check("final_q_valid", 32'(q_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
